odo_sbox_bank: RTL and testbench

Parametrised successor to the fixed 6-bit registered S-box ROMs. It is a runtime-writable substitution table of 2^W entries, W bits each, shared by LANES parallel lookup lanes. The lookup path is a 2-stage valid/ready pipeline. It sits in the Odo round datapath, where the miner control logic reloads the table at each epoch change instead of instantiating one fixed-ROM module per S-box variant.

---
 rtl/odo_sbox_pkg.sv | 17 +
 rtl/odo_sbox_table.sv | 71 +++++++
 rtl/odo_sbox_bank.sv | 125 ++++++++++++
 tb/tb_odo_sbox_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/odo_sbox_pkg.sv
// Shared definitions for the Odo runtime-writable S-box bank.
// Optional feature macro: ODO_SBOX_PARITY_EN (per-entry even parity).
package odo_sbox_pkg;

  localparam int SBOX_W     = 6;
  localparam int SBOX_LANES = 4;
  // Widest symbol the parity helper accepts; narrower symbols are zero-extended
  localparam int SBOX_MAX_W = 16;

  typedef logic [SBOX_W-1:0] sbox_sym_t;

  // Even-parity bit: XOR of all symbol bits, so data plus parity has an even count of ones
  function automatic logic sbox_parity(input logic [SBOX_MAX_W-1:0] sym);
    return ^sym;
  endfunction

endpackage

// File: rtl/odo_sbox_table.sv
// Substitution table storage: 2^W entries, identity on reset, one write port,
// LANES combinational read ports (reads see the value before a same-cycle write).
// Optional feature macro: ODO_SBOX_PARITY_EN adds a stored parity bit per entry.
module odo_sbox_table
  import odo_sbox_pkg::*;
#(
  parameter int W     = SBOX_W,
  parameter int LANES = SBOX_LANES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en_i,
  input  logic [W-1:0]       wr_addr_i,
  input  logic [W-1:0]       wr_data_i,
`ifdef ODO_SBOX_PARITY_EN
  input  logic               wr_perr_inj_i,
  output logic [LANES-1:0]   rd_err_o,
`endif
  input  logic [LANES*W-1:0] rd_addr_i,
  output logic [LANES*W-1:0] rd_data_o
);

  localparam int DEPTH = 1 << W;

  logic [W-1:0] mem_q [DEPTH];

  // Entry storage: identity mapping on reset, single-entry update on a write strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= W'(i);
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Independent read port per lane; several lanes may address the same entry
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_data_o[k*W +: W] = mem_q[rd_addr_i[k*W +: W]];
    end
  end

`ifdef ODO_SBOX_PARITY_EN
  logic par_q [DEPTH];

  // Parity storage: computed from the identity value on reset and from the data on write;
  // the inject input deliberately corrupts the stored bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= sbox_parity(SBOX_MAX_W'(W'(i)));
      end
    end else if (wr_en_i) begin
      par_q[wr_addr_i] <= sbox_parity(SBOX_MAX_W'(wr_data_i)) ^ wr_perr_inj_i;
    end
  end

  // Per-lane parity recheck of the entry being read
  always_comb begin
    rd_err_o = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_err_o[k] = par_q[rd_addr_i[k*W +: W]]
                  ^ sbox_parity(SBOX_MAX_W'(mem_q[rd_addr_i[k*W +: W]]));
    end
  end
`endif

endmodule

// File: rtl/odo_sbox_bank.sv
// Odo S-box bank: LANES parallel lookups through a runtime-writable table,
// two-stage valid/ready pipeline (address capture, then table lookup).
// Optional feature macro: ODO_SBOX_PARITY_EN adds out_err and tbl_wr_perr_inj.
module odo_sbox_bank
  import odo_sbox_pkg::*;
#(
  parameter int W     = SBOX_W,
  parameter int LANES = SBOX_LANES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
`ifdef ODO_SBOX_PARITY_EN
  input  logic               tbl_wr_perr_inj,
  output logic [LANES-1:0]   out_err,
`endif
  input  logic               tbl_wr_en,
  input  logic [W-1:0]       tbl_wr_addr,
  input  logic [W-1:0]       tbl_wr_data
);

  logic               readyEn_q;
  logic               s1Valid_q, s1Valid_d;
  logic [LANES*W-1:0] s1Addr_q, s1Addr_d;
  logic               outValid_q, outValid_d;
  logic [LANES*W-1:0] outData_q, outData_d;
  logic [LANES*W-1:0] lookupData;
  logic               s2Adv, s1Adv, inAccept;

`ifdef ODO_SBOX_PARITY_EN
  logic [LANES-1:0]   lookupErr;
  logic [LANES-1:0]   outErr_q, outErr_d;
`endif

  odo_sbox_table #(
    .W     (W),
    .LANES (LANES)
  ) u_table (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (tbl_wr_en),
    .wr_addr_i     (tbl_wr_addr),
    .wr_data_i     (tbl_wr_data),
`ifdef ODO_SBOX_PARITY_EN
    .wr_perr_inj_i (tbl_wr_perr_inj),
    .rd_err_o      (lookupErr),
`endif
    .rd_addr_i     (s1Addr_q),
    .rd_data_o     (lookupData)
  );

  // Handshake and next-state: stage 2 frees up when empty or drained, stage 1 refills
  // when it is empty or moving forward, and table writes block new beats
  always_comb begin
    s2Adv     = !outValid_q || out_ready;
    s1Adv     = s2Adv && s1Valid_q;
    in_ready  = readyEn_q && (!s1Valid_q || s2Adv) && !tbl_wr_en;
    inAccept  = in_valid && in_ready;

    s1Valid_d = s1Valid_q;
    s1Addr_d  = s1Addr_q;
    if (inAccept) begin
      s1Valid_d = 1'b1;
      s1Addr_d  = in_data;
    end else if (s1Adv) begin
      s1Valid_d = 1'b0;
    end

    outValid_d = outValid_q;
    outData_d  = outData_q;
    if (s2Adv) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        outData_d = lookupData;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight and holds off input for one clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readyEn_q  <= 1'b0;
      s1Valid_q  <= 1'b0;
      s1Addr_q   <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      readyEn_q  <= 1'b1;
      s1Valid_q  <= s1Valid_d;
      s1Addr_q   <= s1Addr_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;

`ifdef ODO_SBOX_PARITY_EN
  // Parity error flags travel with the looked-up data
  always_comb begin
    outErr_d = outErr_q;
    if (s2Adv && s1Valid_q) begin
      outErr_d = lookupErr;
    end
  end

  // Error flag register, aligned with out_data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outErr_q <= '0;
    end else begin
      outErr_q <= outErr_d;
    end
  end

  assign out_err = outErr_q;
`endif

endmodule

// File: tb/tb_odo_sbox_bank.sv
// Directed self-checking bench for odo_sbox_bank (W=6, LANES=4).
// Optional feature macro: ODO_SBOX_PARITY_EN enables the parity scenario.
module tb_odo_sbox_bank;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        tbl_wr_en;
  logic [5:0]  tbl_wr_addr;
  logic [5:0]  tbl_wr_data;
`ifdef ODO_SBOX_PARITY_EN
  logic        tbl_wr_perr_inj;
  logic [3:0]  out_err;
`endif

  int passCount;
  int totalCount;
  logic [5:0] perm [64];

  odo_sbox_bank #(
    .W     (6),
    .LANES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
`ifdef ODO_SBOX_PARITY_EN
    .tbl_wr_perr_inj (tbl_wr_perr_inj),
    .out_err         (out_err),
`endif
    .tbl_wr_en       (tbl_wr_en),
    .tbl_wr_addr     (tbl_wr_addr),
    .tbl_wr_data     (tbl_wr_data)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] pack4(input logic [5:0] a, input logic [5:0] b,
                                        input logic [5:0] c, input logic [5:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [23:0] beatAddr(input int b);
    return pack4(6'(b), 6'(b + 8), 6'(b + 16), 6'(b + 32));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [23:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic setPerm(input int idx, input logic [5:0] val);
    logic [5:0] tmp;
    for (int j = 0; j < 64; j++) begin
      if (perm[j] == val) begin
        tmp       = perm[idx];
        perm[idx] = perm[j];
        perm[j]   = tmp;
        break;
      end
    end
  endtask

  initial begin
    int sent;
    int rcv;
    int inFlight;
    logic holdPending;
    logic [23:0] heldData;

    passCount   = 0;
    totalCount  = 0;
    reset       = 1'b1;
    tbl_wr_en   = 1'b0;
    tbl_wr_addr = '0;
    tbl_wr_data = '0;
`ifdef ODO_SBOX_PARITY_EN
    tbl_wr_perr_inj = 1'b0;
`endif
    applyStimulus(1'b0, 24'h0, 1'b1);

    // Known permutation: odd-stride affine map, patched by swaps to pin four entries
    for (int i = 0; i < 64; i++) perm[i] = 6'((i * 5 + 25) % 64);
    setPerm(0, 6'h19);
    setPerm(1, 6'h0d);
    setPerm(2, 6'h3e);
    setPerm(63, 6'h12);

    // Reset state
    step();
    step();
    checkOutput("resetInReady", 32'(in_ready), 32'd0);
    checkOutput("resetOutValid", 32'(out_valid), 32'd0);
    checkOutput("resetOutData", 32'(out_data), 32'd0);
`ifdef ODO_SBOX_PARITY_EN
    checkOutput("resetOutErr", 32'(out_err), 32'd0);
`endif
    reset = 1'b0;
    #1;
    checkOutput("releaseInReady", 32'(in_ready), 32'd0);
    step();
    checkOutput("firstClkInReady", 32'(in_ready), 32'd1);

    // Identity lookup, two-register latency
    applyStimulus(1'b1, pack4(6'd3, 6'd17, 6'd40, 6'd63), 1'b1);
    step();
    applyStimulus(1'b0, 24'h0, 1'b1);
    #1;
    checkOutput("identLatency", 32'(out_valid), 32'd0);
    step();
    checkOutput("identValid", 32'(out_valid), 32'd1);
    checkOutput("identData", 32'(out_data), 32'(pack4(6'd3, 6'd17, 6'd40, 6'd63)));
    step();
    checkOutput("identDrained", 32'(out_valid), 32'd0);

    // Load the permutation, then look up pinned entries
    for (int i = 0; i < 64; i++) begin
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = 6'(i);
      tbl_wr_data = perm[i];
      if (i == 0) begin
        in_valid = 1'b1;
        #1;
        checkOutput("writeBlocksIn", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
      end
      step();
    end
    tbl_wr_en = 1'b0;
    applyStimulus(1'b1, pack4(6'd0, 6'd1, 6'd2, 6'd63), 1'b1);
    step();
    applyStimulus(1'b0, 24'h0, 1'b1);
    step();
    checkOutput("permValid", 32'(out_valid), 32'd1);
    checkOutput("permData", 32'(out_data), 32'(pack4(6'h19, 6'h0d, 6'h3e, 6'h12)));
    step();

    // Backpressure stream: out_ready pattern 1,0,0,1 repeating
    sent        = 0;
    rcv         = 0;
    inFlight    = 0;
    holdPending = 1'b0;
    heldData    = '0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      applyStimulus(sent < 8, (sent < 8) ? beatAddr(sent) : 24'h0,
                    (cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (inFlight == 2 && !out_ready) checkOutput("fullStallInReady", 32'(in_ready), 32'd0);
      if (out_valid && holdPending) checkOutput("stallHold", 32'(out_data), 32'(heldData));
      holdPending = out_valid && !out_ready;
      heldData    = out_data;
      if (out_valid && out_ready) begin
        checkOutput("streamOrder", 32'(out_data),
                    32'(pack4(perm[rcv], perm[rcv + 8], perm[rcv + 16], perm[rcv + 32])));
        rcv++;
        inFlight--;
      end
      if (in_valid && in_ready) begin
        sent++;
        inFlight++;
      end
      step();
    end
    checkOutput("streamCount", 32'(rcv), 32'd8);
    applyStimulus(1'b0, 24'h0, 1'b1);
    step();
    step();

    // Reset mid-stream with two beats in flight
    applyStimulus(1'b1, pack4(6'd4, 6'd5, 6'd6, 6'd7), 1'b1);
    step();
    applyStimulus(1'b1, pack4(6'd8, 6'd9, 6'd10, 6'd11), 1'b1);
    step();
    checkOutput("preResetValid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 24'h0, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("asyncOutValid", 32'(out_valid), 32'd0);
    checkOutput("asyncInReady", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("noStaleBeat", 32'(out_valid), 32'd0);
    end
    applyStimulus(1'b1, pack4(6'd5, 6'd9, 6'd0, 6'd63), 1'b1);
    step();
    applyStimulus(1'b0, 24'h0, 1'b1);
    step();
    checkOutput("identRestored", 32'(out_data), 32'(pack4(6'd5, 6'd9, 6'd0, 6'd63)));
    step();

    // Write collision: beat for entry 5 sits in stage 1 while entry 5 is rewritten
    applyStimulus(1'b1, pack4(6'd5, 6'd5, 6'd5, 6'd5), 1'b1);
    step();
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 6'd5;
    tbl_wr_data = 6'h2a;
    #1;
    checkOutput("collideInReady", 32'(in_ready), 32'd0);
    step();
    tbl_wr_en = 1'b0;
    checkOutput("collideOldValue", 32'(out_data), 32'(pack4(6'd5, 6'd5, 6'd5, 6'd5)));
    step();
    applyStimulus(1'b0, 24'h0, 1'b1);
    step();
    checkOutput("collideNewValue", 32'(out_data), 32'(pack4(6'h2a, 6'h2a, 6'h2a, 6'h2a)));
    step();

`ifdef ODO_SBOX_PARITY_EN
    // Parity: corrupt stored parity of entry 9
    tbl_wr_en       = 1'b1;
    tbl_wr_addr     = 6'd9;
    tbl_wr_data     = 6'd9;
    tbl_wr_perr_inj = 1'b1;
    step();
    tbl_wr_en       = 1'b0;
    tbl_wr_perr_inj = 1'b0;
    applyStimulus(1'b1, pack4(6'd9, 6'd9, 6'd1, 6'd2), 1'b1);
    step();
    applyStimulus(1'b1, pack4(6'd0, 6'd1, 6'd2, 6'd63), 1'b1);
    step();
    applyStimulus(1'b0, 24'h0, 1'b1);
    checkOutput("parityErrData", 32'(out_data), 32'(pack4(6'd9, 6'd9, 6'd1, 6'd2)));
    checkOutput("parityErrFlags", 32'(out_err), 32'h3);
    step();
    checkOutput("parityCleanFlags", 32'(out_err), 32'h0);
    step();
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
